escalonador_ticks: RTL and testbench
====================================

Name: escalonador_ticks

Overview:
- Single-clock tick scheduler that generates the toy's timebases as clock enables, so no ripple-derived clocks are needed.
- Three independent channels: 0 = main/motor timebase, 1 = auxiliary timebase, 2 = button sampling.
- Each channel produces a one-cycle tick pulse and a 50%-duty square wave.
- Periods are reprogrammed at run time by the main control FSM through a valid/ready config port; a global enable starts and stops all channels.

Parameters:
- CNT_W, 26, width of each channel's period register and counter.
- DEF_P0, 50000000, channel 0 period in clk cycles after reset (1 Hz at 50 MHz).
- DEF_P1, 25000000, channel 1 period after reset.
- DEF_P2, 250000, channel 2 period after reset (200 Hz button sampling).

Ports:
- clk  input  1  board clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = channels count; 0 = channels hold.
- cfg_valid  input  1  config request present.
- cfg_sel  input  2  target channel, 0..2; value 3 is illegal.
- cfg_period  input  CNT_W  new period in clk cycles.
- cfg_ready  output  1  block can accept a config request.
- cfg_err  output  1  sticky flag: an illegal cfg_sel was accepted.
- tick  output  3  one-cycle pulse per channel at its terminal count.
- sq  output  3  square wave per channel; toggles on each of its ticks.
- running  output  1  1 while the FSM is in RUN.

Behaviour:
- Reset values, applied at the clk edge while reset=1:
  - state=IDLE; period[i]=DEF_Pi; cnt[i]=0.
  - tick=0, sq=0, cfg_err=0, running=0, cfg_ready=1.
- Reset has priority over every other input. It aborts a LOAD in progress; the interrupted write is discarded.
- FSM states: IDLE, RUN, LOAD.
  - IDLE: counters hold, tick=0. Go to RUN when enable=1.
  - RUN: counters advance, running=1. Go to IDLE when enable=0; counters hold their value and are not cleared.
  - A handshake (cfg_valid & cfg_ready) in IDLE or RUN moves the FSM to LOAD for exactly one cycle. The FSM then returns to RUN if enable=1 at that edge, otherwise to IDLE.
  - LOAD: cfg_ready=0; counters of non-target channels keep advancing if enable=1. No other state gates cfg_ready.
- Config write, performed at the handshake edge:
  - period[cfg_sel] = max(cfg_period, 2); values 0 and 1 are clamped to 2.
  - cnt[cfg_sel]=0; sq[cfg_sel] is unchanged.
  - cfg_sel=3: no register changes, cfg_err set to 1. The handshake still completes and LOAD is still entered.
  - Maximum throughput is one write every 2 cycles.
- Counting, per channel i, on each cycle counters advance:
  - If cnt[i] == period[i]-1: cnt[i]=0, tick[i]=1 for the next cycle only, sq[i] toggles.
  - Otherwise cnt[i]=cnt[i]+1, tick[i]=0.
  - Tick period is exactly period[i] cycles; sq period is 2*period[i].
  - The first tick after reset plus enable occurs period[i] cycles after the first counting edge.
- Arithmetic: unsigned, CNT_W bits. The comparison uses period-1; the counter never exceeds period-1.
- Simultaneous events:
  - A config write on a channel at its terminal-count edge wins: cnt=0, no tick, no sq toggle.
  - Other channels tick normally in the same cycle.
  - enable falling at a terminal-count edge: no tick, and the count is held at period-1. The tick fires on the first counting edge after re-enable.
- tick outputs are registered, so there is no combinational path from inputs to tick or sq.
- cfg_ready is a pure function of state.

Test Plan:
- Reset then enable=1 with DEF_P2 overridden to 4: tick[2] high on cycles 4, 8, 12 after the first counting edge; sq[2] toggles at the same edges; running=1 from cycle 1.
- In RUN, write cfg_sel=1, cfg_period=3: cfg_ready=0 for exactly the next cycle; cnt[1] restarts; tick[1] every 3 cycles thereafter; channels 0 and 2 keep phase undisturbed.
- Write cfg_period=0 and then 1 to channel 0: both stored as 2; tick[0] every 2 cycles and sq[0] toggles every 2 cycles.
- Write cfg_sel=3: cfg_err=1 and stays 1 until reset; all periods unchanged; cfg_ready still drops for one cycle.
- Drop enable for 10 cycles mid-count with channel 2 at count 2 of period 4: tick=0 throughout, running=0; after re-enable, tick[2] after exactly 2 counting edges.
- Assert reset during LOAD with cfg_valid held high: next cycle all periods equal the defaults, cfg_ready=1, state IDLE; the write is accepted again only on a new handshake after reset.

Source files
------------

// File: rtl/escalonador_ticks.sv
// Three-channel tick scheduler producing clock enables and square waves.
// Periods are reprogrammed at run time through a valid/ready config port.
module escalonador_ticks #(
  parameter int CNT_W  = 26,
  parameter int DEF_P0 = 50000000,
  parameter int DEF_P1 = 25000000,
  parameter int DEF_P2 = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [2:0]       tick,
  output logic [2:0]       sq,
  output logic             running
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             hs;
  logic             adv;
  logic [2:0]       wr;
  logic             bad_sel;
  logic [CNT_W-1:0] per_cl;

  assign cfg_ready = (state != LOAD);
  assign running   = (state == RUN);
  assign hs        = cfg_valid & cfg_ready;
  assign bad_sel   = (cfg_sel == 2'd3);

  // LOAD still counts: only the written channel is restarted.
  assign adv = enable & ((state == RUN) | (state == LOAD));

  assign per_cl = (cfg_period < MIN_P) ? MIN_P : cfg_period;

  always_comb begin
    state_nx = IDLE;
    if (hs) begin
      state_nx = LOAD;
    end else if (enable) begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else if (hs & bad_sel) begin
      cfg_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DEF =
      (i == 0) ? CNT_W'(DEF_P0) :
      (i == 1) ? CNT_W'(DEF_P1) :
                 CNT_W'(DEF_P2);

    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             sq_q;
    logic             term;

    assign wr[i] = hs & (cfg_sel == 2'(i));
    assign term  = (cnt_q == per_q - CNT_W'(1));

    // A write at the terminal edge wins: restart, no tick, no toggle.
    always_ff @(posedge clk) begin
      if (reset) begin
        per_q  <= DEF;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (wr[i]) begin
          per_q <= per_cl;
          cnt_q <= '0;
        end else if (adv) begin
          if (term) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            sq_q   <= ~sq_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_escalonador_ticks.sv
// Bench for escalonador_ticks: table vectors plus scoreboarded sequences.
// A cycle model pushes expected outputs; a monitor pops after each edge.
module tb_escalonador_ticks;

  localparam int CW = 26;
  localparam int P0 = 6;
  localparam int P1 = 5;
  localparam int P2 = 4;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_LOAD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_sel = 2'd0;
  logic [CW-1:0] cfg_period = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic [2:0]    tick;
  logic [2:0]    sq;
  logic          running;

  escalonador_ticks #(
    .CNT_W (CW),
    .DEF_P0(P0),
    .DEF_P1(P1),
    .DEF_P2(P2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_sel   (cfg_sel),
    .cfg_period(cfg_period),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] tick;
    logic [2:0] sq;
    logic       rdy;
    logic       err;
    logic       run;
    bit         tab;
    logic       t2;
    logic       s2;
    logic       trun;
  } exp_t;

  typedef struct {
    bit            rst;
    bit            en;
    bit            v;
    logic [1:0]    sel;
    logic [CW-1:0] per;
    logic          t2;
    logic          s2;
    logic          run;
  } vec_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  int         m_st;
  int         m_per[3];
  int         m_cnt[3];
  logic [2:0] m_sq;
  logic       m_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
  endtask

  // Reference model: updates to the post-edge state and queues outputs.
  task automatic step(input bit rst, input bit en, input bit v,
                      input logic [1:0] sel, input logic [CW-1:0] per,
                      input bit tab = 0, input logic t2 = 0,
                      input logic s2 = 0, input logic trun = 0);
    exp_t       e;
    logic [2:0] nt;
    bit         hs;
    bit         adv;
    @(negedge clk);
    reset      = rst;
    enable     = en;
    cfg_valid  = v;
    cfg_sel    = sel;
    cfg_period = per;
    nt = 3'b000;
    if (rst) begin
      m_st  = S_IDLE;
      m_per = '{P0, P1, P2};
      m_cnt = '{0, 0, 0};
      m_sq  = 3'b000;
      m_err = 1'b0;
    end else begin
      hs  = v && (m_st != S_LOAD);
      adv = en && (m_st == S_RUN || m_st == S_LOAD);
      for (int i = 0; i < 3; i++) begin
        if (hs && int'(sel) == i) begin
          m_per[i] = (per < 2) ? 2 : int'(per);
          m_cnt[i] = 0;
        end else if (adv) begin
          if (m_cnt[i] + 1 == m_per[i]) begin
            m_cnt[i] = 0;
            nt[i]    = 1'b1;
            m_sq[i]  = ~m_sq[i];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (hs && sel == 2'd3) m_err = 1'b1;
      m_st = hs ? S_LOAD : (en ? S_RUN : S_IDLE);
    end
    e.tick = nt;
    e.sq   = m_sq;
    e.rdy  = (m_st != S_LOAD);
    e.err  = m_err;
    e.run  = (m_st == S_RUN);
    e.tab  = tab;
    e.t2   = t2;
    e.s2   = s2;
    e.trun = trun;
    sb.push_back(e);
  endtask

  task automatic idle_run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 2'd0, '0);
  endtask

  task automatic reach_cnt(input int ch, input int val);
    for (int k = 0; k < 60; k++) begin
      if (m_cnt[ch] == val) break;
      step(0, 1, 0, 2'd0, '0);
    end
    chk($sformatf("reach_cnt%0d", ch), m_cnt[ch], val);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("tick", tick, e.tick);
      chk("sq", sq, e.sq);
      chk("cfg_ready", cfg_ready, e.rdy);
      chk("cfg_err", cfg_err, e.err);
      chk("running", running, e.run);
      if (e.tab) begin
        chk("tab_tick2", tick[2], e.t2);
        chk("tab_sq2", sq[2], e.s2);
        chk("tab_running", running, e.trun);
      end
    end
  end

  initial begin
    vec_t        vt[15];
    logic [14:0] t2_col;
    logic [14:0] s2_col;
    logic [14:0] rn_col;
    t2_col = 15'b100010001000000;
    s2_col = 15'b100001111000000;
    rn_col = 15'b111111111111100;
    for (int i = 0; i < 15; i++) begin
      vt[i] = '{rst: (i < 2), en: (i >= 2), v: 1'b0, sel: 2'd0,
                per: '0, t2: t2_col[i], s2: s2_col[i], run: rn_col[i]};
    end

    for (int i = 0; i < 15; i++) begin
      step(vt[i].rst, vt[i].en, vt[i].v, vt[i].sel, vt[i].per,
           1, vt[i].t2, vt[i].s2, vt[i].run);
    end

    step(0, 1, 1, 2'd1, CW'(3));
    idle_run(12);

    step(0, 1, 1, 2'd0, CW'(0));
    idle_run(5);
    step(0, 1, 1, 2'd0, CW'(1));
    idle_run(8);

    step(0, 1, 1, 2'd3, CW'(7));
    idle_run(6);

    reach_cnt(2, 2);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 2'd0, '0);
    idle_run(6);

    reach_cnt(2, 3);
    step(0, 0, 0, 2'd0, '0);
    step(0, 0, 0, 2'd0, '0);
    idle_run(6);

    reach_cnt(1, 2);
    step(0, 1, 1, 2'd1, CW'(4));
    idle_run(8);

    step(0, 1, 1, 2'd1, CW'(3));
    step(0, 1, 1, 2'd1, CW'(3));
    step(0, 1, 1, 2'd1, CW'(3));
    idle_run(4);

    step(0, 1, 1, 2'd0, CW'(9));
    step(1, 1, 1, 2'd0, CW'(9));
    step(0, 1, 1, 2'd0, CW'(9));
    step(0, 1, 0, 2'd0, '0);
    idle_run(12);

    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
           CW'($urandom_range(0, 7)));
    end

    step(0, 0, 0, 2'd0, '0);
    @(posedge clk);
    #2;
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
